// File: rtl/ame_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between REQ_NUM AME requesters.
// Optional AME_DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and returns all ones.
module ame_div_arbiter #(
    parameter int COMP_DATA_BITS = 64,
    parameter int REQ_NUM        = 4,
    parameter int REQ_ID_BITS    = $clog2(REQ_NUM)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic [REQ_NUM-1:0]                            req_valid_i,
    input  logic [REQ_NUM-1:0][1:0][COMP_DATA_BITS-1:0]   req_data_i,
    output logic [REQ_NUM-1:0]                            req_done_o,
    output logic [COMP_DATA_BITS-1:0]                     res_data_o,
    output logic [REQ_ID_BITS-1:0]                        res_id_o,
    output logic                                          busy_o,
    output logic                                          div_init_o,
    output logic [1:0][COMP_DATA_BITS-1:0]                div_data_o,
    input  logic                                          div_done_i,
    input  logic [COMP_DATA_BITS-1:0]                     div_data_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e                            state_q, state_d;
    logic [REQ_ID_BITS-1:0]            ptr_q, ptr_d;
    logic [REQ_ID_BITS-1:0]            idx_q, idx_d;
    logic [REQ_ID_BITS-1:0]            res_id_q, res_id_d;
    logic [1:0][COMP_DATA_BITS-1:0]    ops_q, ops_d;
    logic [COMP_DATA_BITS-1:0]         res_q, res_d;
    logic [REQ_ID_BITS-1:0]            pick;

    // Walk down so the lowest offset from the pointer is the last (winning) assignment.
    always_comb begin
        int cand;
        cand = 0;
        pick = ptr_q;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= REQ_NUM) cand = cand - REQ_NUM;
            if (req_valid_i[REQ_ID_BITS'(cand)]) pick = REQ_ID_BITS'(cand);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        ops_d    = ops_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    idx_d   = pick;
                    ops_d   = req_data_i[pick];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef AME_DIV_ZERO_BYPASS_EN
                // Zero check uses the registered divisor, so done lands two cycles after sampling.
                if (ops_q[1] == '0) begin
                    res_d    = '1;
                    res_id_d = idx_q;
                    state_d  = DONE;
                end else begin
                    state_d = WAIT;
                end
`else
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (div_done_i) begin
                    res_d    = div_data_i;
                    res_id_d = idx_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ptr_d   = (idx_q == REQ_ID_BITS'(REQ_NUM - 1)) ? '0 : idx_q + REQ_ID_BITS'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            ops_q    <= '0;
            res_q    <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            ops_q    <= ops_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
        end
    end

    always_comb begin
        req_done_o = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            req_done_o[i] = (state_q == DONE) && (idx_q == REQ_ID_BITS'(i));
        end
    end

`ifdef AME_DIV_ZERO_BYPASS_EN
    assign div_init_o = (state_q == ISSUE) && (ops_q[1] != '0);
`else
    assign div_init_o = (state_q == ISSUE);
`endif

    assign busy_o     = (state_q != IDLE);
    assign div_data_o = ops_q;
    assign res_data_o = res_q;
    assign res_id_o   = res_id_q;

endmodule

// File: tb/tb_ame_div_arbiter.sv
// Bench for ame_div_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ame_div_arbiter;

    localparam int W   = 64;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i = 1'b0;
    logic [N-1:0]             req_valid_i = '0;
    logic [N-1:0][1:0][W-1:0] req_data_i = '0;
    logic [N-1:0]             req_done_o;
    logic [W-1:0]             res_data_o;
    logic [IDW-1:0]           res_id_o;
    logic                     busy_o;
    logic                     div_init_o;
    logic [1:0][W-1:0]        div_data_o;
    logic                     div_done_i = 1'b0;
    logic [W-1:0]             div_data_i = '0;

    ame_div_arbiter #(.COMP_DATA_BITS(W), .REQ_NUM(N), .REQ_ID_BITS(IDW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_done_o(req_done_o), .res_data_o(res_data_o), .res_id_o(res_id_o),
        .busy_o(busy_o), .div_init_o(div_init_o), .div_data_o(div_data_o),
        .div_done_i(div_done_i), .div_data_i(div_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: one operation in flight, tracked by the cycle numbers of its events.
    int           cyc = 0;
    bit           m_act, m_byp;
    int           m_ptr, m_id, m_init_cyc, m_done_cyc, m_resid;
    logic [W-1:0] m_dvs, m_dvd, m_res;
    int           init_seen = 0;

    // Divider stand-in and stimulus controls.
    int           div_cnt = 0;
    logic [W-1:0] div_q_pend = '0;
    bit           spur_en = 1'b0;
    bit           auto_req = 1'b0;

    function automatic logic [W-1:0] ref_quot(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        return (dvs == '0) ? '1 : dvd / dvs;
    endfunction

    function automatic logic [1:0][W-1:0] rand_ops();
        logic [1:0][W-1:0] o;
        o[0] = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       o[1] = '0;
            1:       o[1] = W'($urandom_range(1, 1000));
            2:       o[1] = {32'h0, $urandom};
            default: o[1] = {$urandom, $urandom};
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_act = 0; m_byp = 0; m_ptr = 0; m_id = 0; m_resid = 0;
        m_init_cyc = -10; m_done_cyc = -1;
        m_dvs = '0; m_dvd = '0; m_res = '0;
    endtask

    // Applies what the clock edge starting cycle `cyc` should do.
    task automatic model_edge();
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        if (m_act && m_done_cyc == cyc - 1) begin
            m_act = 0;
            m_ptr = (m_id + 1) % N;
        end else if (!m_act) begin
            if (req_valid_i != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid_i[(m_ptr + k) % N]) begin
                        m_id = (m_ptr + k) % N;
                        break;
                    end
                end
                m_act = 1; m_init_cyc = cyc; m_done_cyc = -1;
                m_dvs = req_data_i[m_id][1];
                m_dvd = req_data_i[m_id][0];
`ifdef AME_DIV_ZERO_BYPASS_EN
                m_byp = (m_dvs == '0);
`else
                m_byp = 0;
`endif
            end
        end else if (m_done_cyc < 0) begin
            if ((m_byp && cyc - 1 == m_init_cyc) ||
                (!m_byp && cyc - 1 > m_init_cyc && div_done_i)) begin
                m_done_cyc = cyc;
                m_res      = m_byp ? '1 : ref_quot(m_dvd, m_dvs);
                m_resid    = m_id;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] one;
        logic [N-1:0] e_done;
        bit           e_init;
        one    = 1;
        e_init = m_act && !m_byp && (cyc == m_init_cyc);
        e_done = (m_act && cyc == m_done_cyc) ? (one << m_id) : '0;
        if (div_init_o) init_seen++;
        chk("busy", busy_o, m_act);
        chk("div_init", div_init_o, e_init);
        chk("req_done", req_done_o, e_done);
        chk("res_data", res_data_o, m_res);
        chk("res_id", res_id_o, m_resid);
        if (e_init) begin
            chk("div_divisor", div_data_o[1], m_dvs);
            chk("div_dividend", div_data_o[0], m_dvd);
        end
    endtask

    task automatic divider_drive();
        div_done_i = 1'b0;
        if (!rst_n_i) begin
            div_cnt = 0;
            return;
        end
        if (div_init_o) begin
            div_cnt    = $urandom_range(1, 6);
            div_q_pend = ref_quot(div_data_o[0], div_data_o[1]);
        end else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
                div_done_i = 1'b1;
                div_data_i = div_q_pend;
            end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            div_done_i = 1'b1;
            div_data_i = {$urandom, $urandom};
        end
    endtask

    task automatic requester_drive();
        for (int i = 0; i < N; i++) begin
            if (req_done_o[i]) begin
                req_valid_i[i] = 1'b0;
            end else if (auto_req) begin
                if (!req_valid_i[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_data_i[i]  = rand_ops();
                        req_valid_i[i] = 1'b1;
                    end
                end else begin
                    if ($urandom_range(0, 15) == 0) req_data_i[i] = rand_ops();
                    if ($urandom_range(0, 47) == 0) req_valid_i[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        model_edge();
        @(negedge clk_i);
        compare();
        divider_drive();
        requester_drive();
    endtask

    task automatic wait_done(output int id, output int lat);
        id  = -1;
        lat = -1;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (req_done_o != '0) begin
                for (int j = 0; j < N; j++) if (req_done_o[j]) id = j;
                lat = t + 1;
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic wait_init();
        for (int t = 0; t < 20; t++) begin
            tick();
            if (div_init_o) return;
        end
        chk("init_timeout", 0, 1);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] dvs, input logic [W-1:0] dvd);
        req_data_i[i][1] = dvs;
        req_data_i[i][0] = dvd;
        req_valid_i[i]   = 1'b1;
    endtask

    initial begin
        int id, lat;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_res", res_data_o, 0);
        chk("rst_div_data", div_data_o, 0);
        rst_n_i = 1'b1;
        tick();

        // All four at once: grant order 0..3, then pointer back at 0
        for (int i = 0; i < N; i++) set_req(i, 64'd10, 64'(10 * (i + 1)));
        for (int k = 0; k < N; k++) begin
            wait_done(id, lat);
            chk("all_id", id, k);
            chk("all_quot", res_data_o, k + 1);
        end
        tick();
        set_req(1, 64'd3, 64'd9);
        set_req(3, 64'd4, 64'd9);
        wait_done(id, lat);
        chk("ptr0_first", id, 1);
        wait_done(id, lat);
        chk("ptr0_second", id, 3);
        tick();

        // Single request (pointer 0 -> ends at 2)
        init_seen = 0;
        set_req(1, 64'd7, 64'd100);
        wait_done(id, lat);
        chk("single_done", req_done_o, 4'b0010);
        chk("single_quot", res_data_o, 14);
        chk("single_id", res_id_o, 1);
        chk("single_inits", init_seen, 1);
        tick();

        // Wrap-around from pointer 2
        set_req(0, 64'd2, 64'd50);
        set_req(3, 64'd5, 64'd50);
        wait_done(id, lat);
        chk("wrap_first", id, 3);
        chk("wrap_first_q", res_data_o, 10);
        wait_done(id, lat);
        chk("wrap_second", id, 0);
        chk("wrap_second_q", res_data_o, 25);
        tick();

        // Operand change and valid drop during WAIT
        set_req(2, 64'd3, 64'd99);
        wait_init();
        tick();
        req_data_i[2][1] = 64'd1;
        req_data_i[2][0] = 64'd1234;
        req_valid_i[2]   = 1'b0;
        wait_done(id, lat);
        chk("midop_id", id, 2);
        chk("midop_quot", res_data_o, 33);
        tick();

        // Reset during WAIT, then service restarts from pointer 0
        set_req(0, 64'd6, 64'd60);
        set_req(1, 64'd5, 64'd60);
        wait_init();
        tick();
        rst_n_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", req_done_o, 0);
        chk("arst_init", div_init_o, 0);
        chk("arst_res", res_data_o, 0);
        model_reset();
        div_cnt    = 0;
        div_done_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        wait_done(id, lat);
        chk("post_rst_id", id, 0);
        chk("post_rst_q", res_data_o, 10);
        wait_done(id, lat);
        chk("post_rst_id2", id, 1);
        chk("post_rst_q2", res_data_o, 12);
        tick();

        // Zero divisor
        init_seen = 0;
        set_req(0, 64'd0, 64'd5);
        wait_done(id, lat);
        chk("div0_id", id, 0);
`ifdef AME_DIV_ZERO_BYPASS_EN
        chk("div0_inits", init_seen, 0);
        chk("div0_latency", lat, 2);
        chk("div0_res", res_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("div0_inits", init_seen, 1);
`endif
        tick();

        // Random traffic with stray divider done pulses
        auto_req = 1'b1;
        spur_en  = 1'b1;
        for (int t = 0; t < 3000; t++) tick();
        auto_req = 1'b0;
        for (int t = 0; t < 200; t++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
